// File: rtl/i2c_seq_master.sv
// rtl/i2c_seq_master.sv - I2C master that runs one sequenced read or write transaction per start request
module i2c_seq_master #(
  parameter int DIV    = 250,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        dev_addr,
  input  logic              rw,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              scl_oe,
  output logic              sda_oe,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              nack
);

  localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_ACK_A = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_ACK_W = 4'd5;
  localparam logic [3:0] S_RDATA = 4'd6;
  localparam logic [3:0] S_MACK  = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;

  logic [3:0]       state;
  logic [QW-1:0]    qcnt;
  logic [1:0]       phase;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             rw_q;
  logic [LEN_W-1:0] rem;
  logic             sda_s;
  logic             run;
  logic             bit_end;

  // A slave holding SCL low while we have released it stretches the bit.
  assign run     = (state != S_IDLE) && !(!scl_oe && !scl_in);
  assign bit_end = run && (qcnt == QW'(DIV - 1)) && (phase == 2'd3);

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      S_START: sda_oe = 1'b1;
      S_ADDR, S_WDATA: begin
        scl_oe = (phase == 2'd0);
        sda_oe = ~shreg[7];
      end
      S_ACK_A, S_ACK_W, S_RDATA: scl_oe = (phase == 2'd0);
      S_MACK: begin
        scl_oe = (phase == 2'd0);
        sda_oe = (rem != '0);
      end
      S_STOP: begin
        scl_oe = (phase == 2'd0);
        sda_oe = (phase < 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      phase    <= 2'd0;
      bitcnt   <= 3'd0;
      shreg    <= 8'd0;
      rw_q     <= 1'b0;
      rem      <= '0;
      sda_s    <= 1'b0;
      rom_addr <= '0;
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;

      if (state == S_IDLE) begin
        qcnt  <= '0;
        phase <= 2'd0;
      end else if (run) begin
        if (qcnt == QW'(DIV - 1)) begin
          qcnt  <= '0;
          phase <= phase + 2'd1;
        end else begin
          qcnt <= qcnt + QW'(1);
        end
      end

      if (state != S_IDLE && phase == 2'd2 && qcnt == '0)
        sda_s <= sda_in;

      if (state == S_IDLE) begin
        // The done cycle itself never launches a new transaction.
        if (start && !done) begin
          state    <= S_START;
          busy     <= 1'b1;
          nack     <= 1'b0;
          shreg    <= {dev_addr, rw};
          rw_q     <= rw;
          rem      <= len;
          rom_addr <= base_addr;
          bitcnt   <= 3'd0;
        end
      end else if (bit_end) begin
        case (state)
          S_START: state <= S_ADDR;
          S_ADDR: begin
            shreg  <= {shreg[6:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= S_ACK_A;
          end
          S_ACK_A, S_ACK_W: begin
            if (sda_s) begin
              nack  <= 1'b1;
              state <= S_STOP;
            end else if (rem == '0) begin
              state <= S_STOP;
            end else if (rw_q) begin
              state <= S_RDATA;
            end else begin
              state <= S_WDATA;
              shreg <= rom_data;
            end
          end
          S_WDATA: begin
            shreg  <= {shreg[6:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state    <= S_ACK_W;
              rom_addr <= rom_addr + ADDR_W'(1);
              rem      <= rem - LEN_W'(1);
            end
          end
          S_RDATA: begin
            shreg  <= {shreg[6:0], sda_s};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state    <= S_MACK;
              rd_data  <= {shreg[6:0], sda_s};
              rd_valid <= 1'b1;
              rem      <= rem - LEN_W'(1);
            end
          end
          S_MACK: state <= (rem != '0) ? S_RDATA : S_STOP;
          S_STOP: begin
            state <= S_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_seq_master.sv
// tb/tb_i2c_seq_master.sv - scoreboard bench with an I2C slave model for i2c_seq_master
module tb_i2c_seq_master;
  localparam int DIV    = 4;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 8;
  localparam int BIT    = 4 * DIV;

  typedef struct {
    logic n;
    int   cycles;
    int   raddr;
  } done_t;

  logic              ck = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [6:0]        dev_addr = 7'd0;
  logic              rw = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              scl_in, sda_in, scl_oe, sda_oe;
  logic [7:0]        rd_data;
  logic              rd_valid, busy, done, nack;

  logic [7:0] rom [16];
  logic       slv_sda_low = 1'b0;
  logic       slv_scl_hold = 1'b0;

  int         exp_bus[$];
  logic [7:0] exp_rd[$];
  logic [7:0] slv_rd[$];
  logic [7:0] rd_plan[$];
  done_t      exp_done[$];
  done_t      mon_e;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic nack_mode = 1'b0, stretch_req = 1'b0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, scl_v, sda_v;
  logic active = 1'b0, s_rw = 1'b0, master_nacked = 1'b0;
  logic [7:0] sh = 8'd0;
  int frame = 0, bitpos = 0, hold_cnt = 0;

  assign rom_data = rom[rom_addr];
  assign scl_in   = ~scl_oe & ~slv_scl_hold;
  assign sda_in   = ~sda_oe & ~slv_sda_low;

  i2c_seq_master #(.DIV(DIV), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .ck(ck), .reset(reset), .start(start), .dev_addr(dev_addr), .rw(rw), .len(len),
    .base_addr(base_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .nack(nack)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Slave: decodes START/STOP and bits on SCL edges, acks, serves read bytes, stretches.
  initial forever begin
    @(negedge ck);
    if (!reset) begin
      active = 1'b0; slv_sda_low = 1'b0; slv_scl_hold = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      scl_v = scl_in;
      sda_v = sda_in;
      if (slv_scl_hold && !scl_oe) begin
        if (hold_cnt == 50) slv_scl_hold = 1'b0;
        else hold_cnt++;
      end
      if (prev_scl && scl_v && prev_sda && !sda_v) begin
        active = 1'b1; frame = 0; bitpos = 0; master_nacked = 1'b0; slv_sda_low = 1'b0;
      end else if (prev_scl && scl_v && !prev_sda && sda_v) begin
        active = 1'b0; slv_sda_low = 1'b0;
      end else if (active && !prev_scl && scl_v) begin
        if (bitpos < 8) sh = {sh[6:0], sda_v};
        if (bitpos == 7 && (frame == 0 || !s_rw)) begin
          if (frame == 0) s_rw = sda_v;
          if (exp_bus.size() == 0) fail("bus_unexpected_byte");
          else check("bus_byte", sh, exp_bus.pop_front());
        end
        if (bitpos == 7 && frame > 0 && s_rw && slv_rd.size() > 0) void'(slv_rd.pop_front());
        if (bitpos == 8 && frame > 0 && s_rw) begin
          if (sda_v) master_nacked = 1'b1;
          if (exp_bus.size() == 0) fail("bus_unexpected_ack");
          else check("master_ack", sda_v, exp_bus.pop_front());
        end
        bitpos++;
      end else if (active && prev_scl && !scl_v) begin
        if (bitpos == 9) begin
          bitpos = 0;
          frame++;
        end
        slv_sda_low = 1'b0;
        if (bitpos == 8 && ((frame == 0) ? !nack_mode : !s_rw)) slv_sda_low = 1'b1;
        if (bitpos < 8 && frame > 0 && s_rw && !nack_mode && !master_nacked && slv_rd.size() > 0)
          slv_sda_low = ~slv_rd[0][7 - bitpos];
        if (stretch_req && frame == 1 && bitpos == 1) begin
          slv_scl_hold = 1'b1; hold_cnt = 0; stretch_req = 1'b0;
        end
      end
      prev_scl = scl_v;
      prev_sda = sda_v;
    end
  end

  // Monitor: pops expected completions and read bytes whenever the DUT presents them.
  initial forever begin
    @(negedge ck);
    if (done) begin
      if (exp_done.size() == 0) fail("done_unexpected");
      else begin
        mon_e = exp_done.pop_front();
        check("done_nack", nack, mon_e.n);
        check("done_cycles", cyc - acc_cyc, mon_e.cycles);
        check("done_rom_addr", rom_addr, mon_e.raddr);
        check("done_busy", busy, 0);
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) fail("rd_unexpected");
      else check("rd_data", rd_data, exp_rd.pop_front());
    end
  end

  task automatic issue(input logic [6:0] d, input logic r, input int n, input int b,
                       input logic nk, input logic st);
    logic [7:0] v;
    done_t e;
    @(negedge ck);
    nack_mode = nk; stretch_req = st;
    dev_addr = d; rw = r; len = LEN_W'(n); base_addr = ADDR_W'(b); start = 1'b1;
    exp_bus.push_back({d, r});
    if (!nk) for (int i = 0; i < n; i++) begin
      if (!r) exp_bus.push_back(rom[(b + i) % 16]);
      else begin
        v = (rd_plan.size() > 0) ? rd_plan.pop_front() : 8'($urandom);
        exp_rd.push_back(v);
        slv_rd.push_back(v);
        exp_bus.push_back((i == n - 1) ? 1 : 0);
      end
    end
    e.n = nk;
    e.cycles = BIT * (2 + 9 * (1 + (nk ? 0 : n))) + (st ? 50 : 0);
    e.raddr = (!r && !nk) ? (b + n) % 16 : b;
    exp_done.push_back(e);
    @(posedge ck);
    @(negedge ck);
    acc_cyc = cyc;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge ck);
      n++;
    end
    if (!done) fail("timeout_done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = {4'(i), 4'($urandom)};
    repeat (3) @(negedge ck);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rom_addr", rom_addr, 0);
    reset = 1'b1;

    // write with an ignored mid-transaction start
    issue(7'h27, 1'b0, 2, 5, 1'b0, 1'b0);
    repeat (100) @(negedge ck);
    start = 1'b1; dev_addr = 7'h7F; len = 8'd9;
    @(negedge ck);
    start = 1'b0;
    check("busy_ignore_start", busy, 1);
    wait_done();

    issue(7'h51, 1'b0, 3, 9, 1'b1, 1'b0);
    wait_done();

    rd_plan.push_back(8'hA5);
    rd_plan.push_back(8'h3C);
    issue(7'h50, 1'b1, 2, 0, 1'b0, 1'b0);
    wait_done();

    issue(7'h33, 1'b0, 2, 3, 1'b0, 1'b1);
    wait_done();

    issue(7'h12, 1'b0, 2, 15, 1'b0, 1'b0);
    wait_done();

    issue(7'h3A, 1'b0, 0, 4, 1'b0, 1'b0);
    wait_done();
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    check("done_cycle_start_busy", busy, 0);
    @(negedge ck);
    check("done_cycle_start_busy2", busy, 0);
    check("done_cycle_start_sda", sda_oe, 0);

    // reset in the middle of the first write byte
    issue(7'h2C, 1'b0, 3, 2, 1'b0, 1'b0);
    repeat (209) @(negedge ck);
    check("pre_reset_scl_low", scl_oe, 1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_scl_oe", scl_oe, 0);
    check("async_rst_sda_oe", sda_oe, 0);
    check("async_rst_busy", busy, 0);
    exp_bus.delete(); exp_rd.delete(); slv_rd.delete(); exp_done.delete();
    stretch_req = 1'b0;
    @(negedge ck);
    check("rst2_rom_addr", rom_addr, 0);
    check("rst2_done", done, 0);
    reset = 1'b1;
    issue(7'h61, 1'b0, 2, 7, 1'b0, 1'b0);
    wait_done();

    for (int t = 0; t < 6; t++) begin
      issue(7'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 15), 1'b0, 1'b0);
      wait_done();
    end

    repeat (5) @(negedge ck);
    check("exp_bus_empty", exp_bus.size(), 0);
    check("exp_rd_empty", exp_rd.size(), 0);
    check("exp_done_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
